filter_event_ctrl: RTL

FILTER_EVENT_CTRL -- requirements
Module: filter_event_ctrl

---
 rtl/filter_event_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/filter_event_ctrl.sv
// filter_event_ctrl: sequences the shaping-filter datapath (reset, flush, arm),
// captures threshold-crossing pulses as {peak amplitude, timestamp, pileup}
// events, and buffers them in a small FIFO for a ready/valid consumer.
module filter_event_ctrl #(
    parameter int SIZE_FILTER_DATA = 16,
    parameter int TS_WIDTH         = 32,
    parameter int FLUSH_CYCLES     = 24,
    parameter int PEAK_WINDOW      = 16,
    parameter int HOLDOFF_CYCLES   = 8,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
    input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
    output logic                               filt_rst_n,
    output logic                               busy,
    output logic                               evt_valid,
    input  logic                               evt_ready,
    output logic signed [SIZE_FILTER_DATA-1:0] evt_amp,
    output logic        [TS_WIDTH-1:0]         evt_ts,
    output logic                               evt_pileup,
    output logic        [7:0]                  drop_cnt
);

    localparam int CNT_MAX = (FLUSH_CYCLES > HOLDOFF_CYCLES) ? FLUSH_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int WIN_W   = $clog2(PEAK_WINDOW + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = SIZE_FILTER_DATA + TS_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_ARMED,
        S_PEAK,
        S_HOLDOFF
    } state_t;

    // Larger of two signed samples; used to track the running pulse maximum.
    function automatic logic signed [SIZE_FILTER_DATA-1:0] max_s(
        input logic signed [SIZE_FILTER_DATA-1:0] a,
        input logic signed [SIZE_FILTER_DATA-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // Increment that sticks at the top of the 8-bit range.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t                               state;
    logic        [CNT_W-1:0]              cnt;
    logic        [WIN_W-1:0]              win_cnt;
    logic signed [SIZE_FILTER_DATA-1:0]   peak;
    logic        [TS_WIDTH-1:0]           cap_ts;
    logic        [TS_WIDTH-1:0]           ts;

    logic        [ENTRY_W-1:0]            mem [FIFO_DEPTH];
    logic        [PTR_W-1:0]              wr_ptr;
    logic        [PTR_W-1:0]              rd_ptr;
    logic        [OCC_W-1:0]              occ;

    logic                                 above_thr;
    logic signed [SIZE_FILTER_DATA-1:0]   peak_next;
    logic                                 win_full;
    logic                                 push_req;
    logic                                 push_pileup;
    logic                                 pop;
    logic                                 full;
    logic                                 wr_en;
    logic                                 drop;

    assign above_thr   = filter_data > threshold;
    assign peak_next   = max_s(peak, filter_data);
    assign win_full    = (win_cnt == WIN_W'(PEAK_WINDOW));
    // A falling edge wins over window expiry, so pileup is only flagged while still above.
    assign push_req    = (state == S_PEAK) && enable && (!above_thr || win_full);
    assign push_pileup = above_thr;

    assign evt_valid = (occ != '0);
    assign full      = (occ == OCC_W'(FIFO_DEPTH));
    assign pop       = evt_valid && evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en     = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    assign {evt_amp, evt_ts, evt_pileup} = mem[rd_ptr];

    // Free-running timestamp, wraps naturally at its width.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_WIDTH'(1);
        end
    end

    // Control FSM: filter reset/flush sequencing, pulse capture and dead time.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            filt_rst_n <= 1'b0;
            busy       <= 1'b0;
            cnt        <= '0;
            win_cnt    <= '0;
            peak       <= '0;
            cap_ts     <= '0;
        end else if ((state != S_IDLE) && !enable) begin
            // Dropping enable abandons any pulse in flight; the FIFO is left alone.
            state      <= S_IDLE;
            filt_rst_n <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state      <= S_FLUSH;
                        cnt        <= CNT_W'(FLUSH_CYCLES - 1);
                        filt_rst_n <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (cnt == '0) begin
                        state <= S_ARMED;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_ARMED: begin
                    if (above_thr) begin
                        state   <= S_PEAK;
                        peak    <= filter_data;
                        cap_ts  <= ts;
                        win_cnt <= WIN_W'(1);
                    end
                end
                S_PEAK: begin
                    peak <= peak_next;
                    if (push_req) begin
                        state <= S_HOLDOFF;
                        cnt   <= CNT_W'(HOLDOFF_CYCLES - 1);
                    end else begin
                        win_cnt <= win_cnt + WIN_W'(1);
                    end
                end
                S_HOLDOFF: begin
                    // Re-arm only once the dead time is over and the pulse has fallen.
                    if (cnt == '0) begin
                        if (!above_thr) begin
                            state <= S_ARMED;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    filt_rst_n <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // Event FIFO with overflow accounting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            drop_cnt <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= {peak_next, cap_ts, push_pileup};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en && !pop) begin
                occ <= occ + OCC_W'(1);
            end else if (!wr_en && pop) begin
                occ <= occ - OCC_W'(1);
            end
            if (drop) begin
                drop_cnt <= sat_inc8(drop_cnt);
            end
        end
    end

endmodule
